pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL provide parameter MD_LAT, default 8: total stall cycles for a mul/div, legal range 2..16.
REQ-002 SHALL provide parameter CNT_W, default 16: width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clrn  input  1  reset; synchronous, active-low.
REQ-005 d_rs  input  5  ID-stage source register rs.
REQ-006 d_rt  input  5  ID-stage source register rt.
REQ-007 d_use_rs, d_use_rt  input  1 each  ID instruction reads rs / rt.
REQ-008 e_wreg  input  1  EX-stage instruction writes the register file.
REQ-009 e_m2reg  input  1  EX-stage instruction is a load.
REQ-010 e_rn  input  5  EX-stage destination register.
REQ-011 d_md  input  1  ID instruction is mul/div.
REQ-012 imem_rdy  input  1  instruction memory data valid this cycle.
REQ-013 d_br_taken  input  1  branch/jump in ID resolved taken.
REQ-014 wpcir  output  1  write enable for PC and IF/ID register; 1 = advance.
REQ-015 fl_ir  output  1  load nop into IF/ID on next edge.
REQ-016 bub_de  output  1  load bubble (all control 0) into ID/EX on next edge.
REQ-017 md_busy  output  1  mul/div in progress.
REQ-018 stall_cnt  output  CNT_W  cycles with wpcir=0 since reset.

Function
REQ-019 SHALL implement states RUN, MDWAIT, IFWAIT.
REQ-020 Load-use hazard lu = e_wreg & e_m2reg & (e_rn!=0) & ((d_use_rs & d_rs==e_rn) | (d_use_rt & d_rt==e_rn)); combinational.
REQ-021 In RUN with lu=1: wpcir=0, bub_de=1, fl_ir=0 in the same cycle; state stays RUN.
REQ-022 In RUN with lu=0, d_md=1: wpcir=0, bub_de=1; next state MDWAIT; md_cnt loaded MD_LAT-2.
REQ-023 In MDWAIT: wpcir=0, bub_de=1, md_busy=1; md_cnt decrements each cycle; when md_cnt=0, next state RUN with d_md ignored that RUN cycle (same instruction must not re-trigger), giving exactly MD_LAT stall cycles.
REQ-024 In RUN with lu=0, d_md=0 (or suppressed), imem_rdy=0: wpcir=0, bub_de=1; next state IFWAIT.
REQ-025 In IFWAIT: wpcir=0, bub_de=1 while imem_rdy=0; on imem_rdy=1 wpcir=1, bub_de=0, next state RUN.
REQ-026 Priority in RUN: lu > d_md > imem_rdy=0; d_md with lu=1 not accepted that cycle.
REQ-027 fl_ir = d_br_taken & wpcir; d_br_taken SHALL be ignored whenever wpcir=0.
REQ-028 Otherwise in RUN: wpcir=1, bub_de=0, md_busy=0.
REQ-029 md_busy SHALL be 1 only in MDWAIT and the cycle d_md is accepted.
REQ-030 stall_cnt SHALL increment on each edge where wpcir=0 and saturate at all-ones (no wrap).
REQ-031 md_cnt SHALL be 4 bits; values other than described never reached.

Reset
REQ-032 On a rising edge with clrn=0: state=RUN, md_cnt=0, stall_cnt=0, md-suppress flag=0, regardless of current state (including mid-MDWAIT/IFWAIT).
REQ-033 While clrn=0: wpcir=0, fl_ir=0, bub_de=1, md_busy=0.
REQ-034 First cycle after clrn rises SHALL behave as RUN with no pending history.

Verification
REQ-035 Load r2 in EX (e_wreg=1,e_m2reg=1,e_rn=2), ID d_rs=2,d_use_rs=1 -> one cycle wpcir=0,bub_de=1; next cycle (hazard gone) wpcir=1; stall_cnt=1.
REQ-036 e_rn=0 with matching d_rs=0 -> no stall, wpcir=1.
REQ-037 d_md=1 held, MD_LAT=8 -> wpcir=0 for exactly 8 cycles, md_busy=1 for those 8, then wpcir=1; stall_cnt=8.
REQ-038 imem_rdy=0 for 3 cycles with d_br_taken=1 -> fl_ir=0 throughout, wpcir=0 3 cycles; cycle imem_rdy=1 -> wpcir=1, fl_ir=1.
REQ-039 lu=1 and d_md=1 same cycle -> load-use stall only; next cycle MDWAIT entry, total 9 stall cycles.
REQ-040 clrn=0 on 3rd MDWAIT cycle -> next edge state RUN, stall_cnt=0, md_busy=0; after release wpcir=1 given imem_rdy=1, d_md=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Bundles the ID/EX hazard inputs and the pipeline stall controls.
// master drives the pipeline-side inputs, slave is the stall controller.
interface pipe_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       d_rs;
   logic [4:0]       d_rt;
   logic             d_use_rs;
   logic             d_use_rt;
   logic             e_wreg;
   logic             e_m2reg;
   logic [4:0]       e_rn;
   logic             d_md;
   logic             imem_rdy;
   logic             d_br_taken;
   logic             wpcir;
   logic             fl_ir;
   logic             bub_de;
   logic             md_busy;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output d_rs, d_rt, d_use_rs, d_use_rt, e_wreg, e_m2reg, e_rn,
             d_md, imem_rdy, d_br_taken,
      input  wpcir, fl_ir, bub_de, md_busy, stall_cnt
   );

   modport slave (
      input  d_rs, d_rt, d_use_rs, d_use_rt, e_wreg, e_m2reg, e_rn,
             d_md, imem_rdy, d_br_taken,
      output wpcir, fl_ir, bub_de, md_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: load-use interlock, multi-cycle mul/div wait,
// instruction-fetch wait, branch flush gating and a saturating stall counter.
module pipe_stall_ctrl #(
   parameter int MD_LAT = 8,
   parameter int CNT_W  = 16
) (
   input logic              clk,
   input logic              clrn,
   pipe_stall_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN, MDWAIT, IFWAIT} state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LAT - 2);

   state_t           state;
   logic [3:0]       md_cnt;
   logic             md_sup;
   logic [CNT_W-1:0] stall_cnt_q;

   logic lu;
   logic md_go;
   logic wpcir_c;
   logic bub_c;
   logic busy_c;

   always_comb begin
      lu = bus.e_wreg && bus.e_m2reg && (bus.e_rn != 5'd0) &&
           ((bus.d_use_rs && (bus.d_rs == bus.e_rn)) ||
            (bus.d_use_rt && (bus.d_rt == bus.e_rn)));
   end

   // Outputs depend on the current-cycle hazard inputs, so they are decoded
   // combinationally from state; reset forces the stalled/bubble pattern.
   always_comb begin
      wpcir_c = 1'b0;
      bub_c   = 1'b1;
      busy_c  = 1'b0;
      md_go   = 1'b0;
      if (clrn) begin
         case (state)
            RUN: begin
               if (lu) begin
                  md_go = 1'b0;
               end else if (bus.d_md && !md_sup) begin
                  md_go  = 1'b1;
                  busy_c = 1'b1;
               end else if (bus.imem_rdy) begin
                  wpcir_c = 1'b1;
                  bub_c   = 1'b0;
               end
            end
            MDWAIT: busy_c = 1'b1;
            IFWAIT: begin
               if (bus.imem_rdy) begin
                  wpcir_c = 1'b1;
                  bub_c   = 1'b0;
               end
            end
            default: busy_c = 1'b0;
         endcase
      end
   end

   assign bus.wpcir     = wpcir_c;
   assign bus.bub_de    = bub_c;
   assign bus.md_busy   = busy_c;
   assign bus.fl_ir     = bus.d_br_taken && wpcir_c;
   assign bus.stall_cnt = stall_cnt_q;

   // md_sup masks d_md for the first RUN cycle after MDWAIT so the mul/div
   // still sitting in ID does not start a second wait.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         state       <= RUN;
         md_cnt      <= 4'd0;
         md_sup      <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         if (!wpcir_c && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         case (state)
            RUN: begin
               md_sup <= 1'b0;
               if (md_go) begin
                  state  <= MDWAIT;
                  md_cnt <= MD_INIT;
               end else if (!lu && !bus.imem_rdy) begin
                  state <= IFWAIT;
               end
            end
            MDWAIT: begin
               if (md_cnt == 4'd0) begin
                  state  <= RUN;
                  md_sup <= 1'b1;
               end else begin
                  md_cnt <= md_cnt - 4'd1;
               end
            end
            IFWAIT: begin
               if (bus.imem_rdy)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazard scenarios then random
// traffic, each cycle predicted by a stall-budget model and checked by a monitor.
module tb_pipe_stall_ctrl;
   localparam int MD_LAT  = 8;
   localparam int CNT_W   = 6;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic       clrn;
      logic [4:0] d_rs;
      logic [4:0] d_rt;
      logic       d_use_rs;
      logic       d_use_rt;
      logic       e_wreg;
      logic       e_m2reg;
      logic [4:0] e_rn;
      logic       d_md;
      logic       imem_rdy;
      logic       d_br_taken;
   } stim_t;

   typedef struct {
      logic  wpcir;
      logic  fl_ir;
      logic  bub_de;
      logic  md_busy;
      int    stall_cnt;
      string tag;
   } exp_t;

   logic clk;
   logic clrn;
   pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_stall_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   exp_t exp_q[$];
   int   checks;
   int   errors;
   int   cyc;

   // Reference model: outstanding mul/div stall budget, fetch-wait flag,
   // and the one-cycle "same instruction" mask after a mul/div finishes.
   int m_md_left;
   bit m_just_done;
   bit m_if_wait;
   int m_cnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   task automatic model_step(input stim_t s, output exp_t e);
      bit stall;
      bit busy;
      bit hazard;
      e.stall_cnt = m_cnt;
      stall = 1'b1;
      busy  = 1'b0;
      if (!s.clrn) begin
         m_md_left = 0; m_just_done = 0; m_if_wait = 0; m_cnt = 0;
         e.wpcir = 0; e.fl_ir = 0; e.bub_de = 1; e.md_busy = 0;
         return;
      end
      if (m_md_left > 0) begin
         busy = 1'b1;
         m_md_left--;
         if (m_md_left == 0) m_just_done = 1;
      end else if (m_if_wait) begin
         if (s.imem_rdy) begin
            stall = 1'b0;
            m_if_wait = 0;
         end
      end else begin
         hazard = s.e_wreg && s.e_m2reg && (s.e_rn != 0) &&
                  ((s.d_use_rs && s.d_rs == s.e_rn) || (s.d_use_rt && s.d_rt == s.e_rn));
         if (hazard) begin
            stall = 1'b1;
         end else if (s.d_md && !m_just_done) begin
            busy = 1'b1;
            m_md_left = MD_LAT - 1;
         end else if (!s.imem_rdy) begin
            m_if_wait = 1;
         end else begin
            stall = 1'b0;
         end
         m_just_done = 0;
      end
      e.wpcir   = !stall;
      e.bub_de  = stall;
      e.fl_ir   = s.d_br_taken && !stall;
      e.md_busy = busy;
      if (stall && m_cnt < CNT_MAX) m_cnt++;
   endtask

   task automatic apply_stimulus(input stim_t s, input string tag);
      exp_t e;
      @(negedge clk);
      clrn           = s.clrn;
      bus.d_rs       = s.d_rs;
      bus.d_rt       = s.d_rt;
      bus.d_use_rs   = s.d_use_rs;
      bus.d_use_rt   = s.d_use_rt;
      bus.e_wreg     = s.e_wreg;
      bus.e_m2reg    = s.e_m2reg;
      bus.e_rn       = s.e_rn;
      bus.d_md       = s.d_md;
      bus.imem_rdy   = s.imem_rdy;
      bus.d_br_taken = s.d_br_taken;
      model_step(s, e);
      e.tag = $sformatf("%s@%0d", tag, cyc);
      cyc++;
      exp_q.push_back(e);
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.clrn = 1'b1;
      s.imem_rdy = 1'b1;
      return s;
   endfunction

   task automatic do_reset(input int n);
      stim_t s;
      s = idle();
      s.clrn = 1'b0;
      repeat (n) apply_stimulus(s, "reset");
   endtask

   // Monitor: every cycle the DUT presents settled outputs, compare them
   // against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output({e.tag, ".wpcir"},     32'(bus.wpcir),     32'(e.wpcir));
            check_output({e.tag, ".fl_ir"},     32'(bus.fl_ir),     32'(e.fl_ir));
            check_output({e.tag, ".bub_de"},    32'(bus.bub_de),    32'(e.bub_de));
            check_output({e.tag, ".md_busy"},   32'(bus.md_busy),   32'(e.md_busy));
            check_output({e.tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(e.stall_cnt));
         end
      end
   end

   initial begin
      stim_t s;
      checks = 0; errors = 0; cyc = 0;
      m_md_left = 0; m_just_done = 0; m_if_wait = 0; m_cnt = 0;
      s = idle();
      s.clrn = 1'b0;
      clrn = 1'b0;
      bus.d_rs = s.d_rs; bus.d_rt = s.d_rt; bus.d_use_rs = 0; bus.d_use_rt = 0;
      bus.e_wreg = 0; bus.e_m2reg = 0; bus.e_rn = 0; bus.d_md = 0;
      bus.imem_rdy = 1; bus.d_br_taken = 0;
      @(posedge clk);
      do_reset(2);

      // load-use on r2
      s = idle(); s.e_wreg = 1; s.e_m2reg = 1; s.e_rn = 5'd2; s.d_rs = 5'd2; s.d_use_rs = 1;
      apply_stimulus(s, "lu_r2");
      s = idle();
      repeat (2) apply_stimulus(s, "lu_after");

      // r0 never interlocks
      do_reset(1);
      s = idle(); s.e_wreg = 1; s.e_m2reg = 1; s.e_rn = 5'd0; s.d_rs = 5'd0; s.d_use_rs = 1;
      s.d_rt = 5'd0; s.d_use_rt = 1;
      apply_stimulus(s, "lu_r0");

      // mul/div held in ID
      do_reset(1);
      s = idle(); s.d_md = 1;
      repeat (MD_LAT + 1) apply_stimulus(s, "md_hold");
      s = idle();
      apply_stimulus(s, "md_done");

      // fetch wait with a taken branch
      do_reset(1);
      s = idle(); s.imem_rdy = 0; s.d_br_taken = 1;
      repeat (3) apply_stimulus(s, "if_wait");
      s.imem_rdy = 1;
      apply_stimulus(s, "if_done");

      // load-use and mul/div together
      do_reset(1);
      s = idle(); s.d_md = 1; s.e_wreg = 1; s.e_m2reg = 1; s.e_rn = 5'd7; s.d_rt = 5'd7; s.d_use_rt = 1;
      apply_stimulus(s, "lu_md");
      s = idle(); s.d_md = 1;
      repeat (MD_LAT) apply_stimulus(s, "lu_md_wait");
      s = idle();
      apply_stimulus(s, "lu_md_done");

      // reset in the middle of a mul/div wait
      do_reset(1);
      s = idle(); s.d_md = 1;
      repeat (3) apply_stimulus(s, "md_pre_rst");
      s.clrn = 1'b0;
      apply_stimulus(s, "md_rst");
      s = idle();
      repeat (2) apply_stimulus(s, "md_post_rst");

      // random traffic; narrow register range to provoke hazards
      for (int i = 0; i < 700; i++) begin
         s.clrn       = 1'($urandom_range(0, 299) != 0);
         s.d_rs       = 5'($urandom_range(0, 3));
         s.d_rt       = 5'($urandom_range(0, 3));
         s.d_use_rs   = 1'($urandom_range(0, 1));
         s.d_use_rt   = 1'($urandom_range(0, 1));
         s.e_wreg     = 1'($urandom_range(0, 1));
         s.e_m2reg    = 1'($urandom_range(0, 1));
         s.e_rn       = 5'($urandom_range(0, 3));
         s.d_md       = 1'($urandom_range(0, 7) == 0);
         s.imem_rdy   = 1'($urandom_range(0, 3) != 0);
         s.d_br_taken = 1'($urandom_range(0, 1));
         apply_stimulus(s, "rand");
      end

      repeat (3) @(negedge clk);
      check_output("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
